// File: rtl/grf_wport_arbiter.sv
`default_nettype none
// ============================================================================
// grf_wport_arbiter
//   Shares the single GRF write port between the pipeline W stage (s0) and a
//   multi-cycle unit (s1). Default policy: s0 has priority, and s1 is forced
//   through after STARVE_MAX consecutive s0 wins. Defining GRF_ARB_RR_EN
//   selects round-robin instead.
//   Revision: 1.0
// ============================================================================
module grf_wport_arbiter #(
    parameter int DW         = 32,
    parameter int AW         = 5,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          s0_valid,
    output logic          s0_ready,
    input  logic [AW-1:0] s0_rd,
    input  logic [DW-1:0] s0_data,
    input  logic [DW-1:0] s0_pc,
    input  logic          s1_valid,
    output logic          s1_ready,
    input  logic [AW-1:0] s1_rd,
    input  logic [DW-1:0] s1_data,
    input  logic [DW-1:0] s1_pc,
    output logic          grf_regw,
    output logic [AW-1:0] grf_rd,
    output logic [DW-1:0] grf_data,
    output logic [DW-1:0] grf_pc
);

    logic          s0_xfer;
    logic          s1_xfer;
    logic          regw_q, regw_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [DW-1:0] data_q, data_d;
    logic [DW-1:0] pc_q, pc_d;

    assign s0_xfer = s0_valid && s0_ready;
    assign s1_xfer = s1_valid && s1_ready;

`ifdef GRF_ARB_RR_EN
    // last_q = 1 means s1 was granted most recently, so s0 wins the next tie.
    logic last_q;

    always_comb begin
        s0_ready = 1'b0;
        s1_ready = 1'b0;
        if (!clr) begin
            if (s0_valid && s1_valid) begin
                s0_ready = last_q;
                s1_ready = !last_q;
            end else begin
                s0_ready = s0_valid;
                s1_ready = s1_valid;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            last_q <= 1'b1;
        end else if (s0_xfer) begin
            last_q <= 1'b0;
        end else if (s1_xfer) begin
            last_q <= 1'b1;
        end
    end
`else
    localparam int            CW         = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] STARVE_CNT = CW'(STARVE_MAX);

    typedef enum logic [0:0] {
        PRIO0  = 1'b0,
        FORCE1 = 1'b1
    } state_t;

    state_t        state_q;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_inc;

    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        s0_ready = 1'b0;
        s1_ready = 1'b0;
        if (!clr) begin
            if (state_q == PRIO0) begin
                s0_ready = s0_valid;
                s1_ready = s1_valid && !s0_valid;
            end else begin
                s1_ready = s1_valid;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= PRIO0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                PRIO0: begin
                    if (s0_xfer && s1_valid) begin
                        cnt_q <= cnt_inc;
                        if (cnt_inc == STARVE_CNT) begin
                            state_q <= FORCE1;
                        end
                    end else begin
                        cnt_q <= '0;
                    end
                end
                // s1 either transfers here or has dropped valid; both return to PRIO0.
                default: begin
                    state_q <= PRIO0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end
`endif

    always_comb begin
        regw_d = 1'b0;
        rd_d   = rd_q;
        data_d = data_q;
        pc_d   = pc_q;
        if (s0_xfer) begin
            regw_d = (s0_rd != '0);
            rd_d   = s0_rd;
            data_d = s0_data;
            pc_d   = s0_pc;
        end else if (s1_xfer) begin
            regw_d = (s1_rd != '0);
            rd_d   = s1_rd;
            data_d = s1_data;
            pc_d   = s1_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            regw_q <= 1'b0;
            rd_q   <= '0;
            data_q <= '0;
            pc_q   <= '0;
        end else begin
            regw_q <= regw_d;
            rd_q   <= rd_d;
            data_q <= data_d;
            pc_q   <= pc_d;
        end
    end

    assign grf_regw = regw_q;
    assign grf_rd   = rd_q;
    assign grf_data = data_q;
    assign grf_pc   = pc_q;

endmodule
`default_nettype wire
